// File: rtl/gon_gather_bus_rr.sv
// rtl/gon_gather_bus_rr.sv - tag-filtered round-robin gather bus with 2-entry output buffer
module gon_gather_bus_rr #(
  parameter int NUMS_MASTER = 4,
  parameter int ID_SIZE     = 8,
  parameter int DATA_SIZE   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ID_SIZE-1:0]               tag,
  input  logic [NUMS_MASTER-1:0]           master_valid,
  input  logic [NUMS_MASTER*DATA_SIZE-1:0] master_data,
  output logic [NUMS_MASTER-1:0]           master_ready,
  output logic                             slave_valid,
  input  logic                             slave_ready,
  output logic [DATA_SIZE-1:0]             slave_data,
  input  logic                             set_id,
  input  logic [ID_SIZE-1:0]               ID_scan_in,
  output logic [ID_SIZE-1:0]               ID_scan_out
);

  localparam int PW = (NUMS_MASTER > 1) ? $clog2(NUMS_MASTER) : 1;

  logic [ID_SIZE-1:0]   id [NUMS_MASTER];
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        gnt;
  logic [NUMS_MASTER-1:0] elig;
  logic                 any_elig;
  int                   arb_idx;

  logic [DATA_SIZE-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;
  logic [DATA_SIZE-1:0] push_data;

  always_comb begin
    for (int i = 0; i < NUMS_MASTER; i++) begin
      elig[i] = master_valid[i] && (id[i] == tag) && !set_id;
    end
  end

  // Search begins just after the last winner so every matching master gets a turn.
  always_comb begin
    gnt      = '0;
    any_elig = 1'b0;
    arb_idx  = 0;
    for (int k = 1; k <= NUMS_MASTER; k++) begin
      arb_idx = (int'(ptr) + k) % NUMS_MASTER;
      if (!any_elig && elig[arb_idx]) begin
        any_elig = 1'b1;
        gnt      = PW'(arb_idx);
      end
    end
  end

  assign push      = any_elig && (count != 2'd2);
  assign pop       = slave_valid && slave_ready;
  assign push_data = master_data[gnt*DATA_SIZE +: DATA_SIZE];

  always_comb begin
    master_ready = '0;
    if (push && !rst) begin
      master_ready[gnt] = 1'b1;
    end
  end

  assign slave_valid = (count != 2'd0);
  assign slave_data  = mem[rd_ptr];
  assign ID_scan_out = id[NUMS_MASTER-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUMS_MASTER; i++) begin
        id[i] <= '0;
      end
      ptr    <= PW'(NUMS_MASTER - 1);
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (set_id) begin
        id[0] <= ID_scan_in;
        for (int i = 1; i < NUMS_MASTER; i++) begin
          id[i] <= id[i-1];
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
        ptr         <= gnt;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gon_gather_bus_rr.sv
// tb/tb_gon_gather_bus_rr.sv - scoreboard bench for gon_gather_bus_rr
module tb_gon_gather_bus_rr;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic [IW-1:0]   tag;
  logic [N-1:0]    master_valid;
  logic [N*DW-1:0] master_data;
  logic [N-1:0]    master_ready;
  logic            slave_valid;
  logic            slave_ready;
  logic [DW-1:0]   slave_data;
  logic            set_id;
  logic [IW-1:0]   ID_scan_in;
  logic [IW-1:0]   ID_scan_out;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  gon_gather_bus_rr #(.NUMS_MASTER(N), .ID_SIZE(IW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst), .tag(tag),
    .master_valid(master_valid), .master_data(master_data), .master_ready(master_ready),
    .slave_valid(slave_valid), .slave_ready(slave_ready), .slave_data(slave_data),
    .set_id(set_id), .ID_scan_in(ID_scan_in), .ID_scan_out(ID_scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int m, input logic [DW-1:0] v);
    master_data[m*DW +: DW] = v;
  endtask

  // Monitor: every accepted slave beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && slave_valid && slave_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL slave_beat: got %0h expected none", slave_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (slave_data !== e) begin
          errors++;
          $display("FAIL slave_data: got %0h expected %0h", slave_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [N-1:0]  exp_gnt [6];
    logic [DW-1:0] exp_dat [6];
    exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    exp_dat = '{8'h10, 8'h11, 8'h13, 8'h10, 8'h11, 8'h13};

    rst = 1'b1; tag = '0; master_valid = '1; master_data = '0;
    slave_ready = 1'b0; set_id = 1'b0; ID_scan_in = '0;
    #2;
    chk("reset_slave_valid", slave_valid, 0);
    chk("reset_master_ready", master_ready, 0);
    chk("reset_scan_out", ID_scan_out, 0);
    chk("reset_slave_data", slave_data, 0);
    master_valid = '0;
    cyc(); cyc();
    rst = 1'b0;

    // ID scan 3,2,1,0 -> id[0..3] = 0,1,2,3
    master_valid = '1;
    set_id = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ID_scan_in = IW'(3 - i);
      @(negedge clk);
      chk("scan_master_ready", master_ready, 0);
      cyc();
    end
    chk("scan_out_after_4", ID_scan_out, 3);
    set_id = 1'b0;
    master_valid = '0;

    // Single match on master 2
    tag = 8'd2; set_data(2, 8'hAB); master_valid = 4'b0100; slave_ready = 1'b1;
    exp_q.push_back(8'hAB);
    @(negedge clk);
    chk("single_grant", master_ready, 4'b0100);
    cyc();
    master_valid = '0;
    @(negedge clk);
    chk("single_slave_valid", slave_valid, 1);
    cyc();

    // Async reset with data buffered
    slave_ready = 1'b0; set_data(2, 8'hCD); master_valid = 4'b0100;
    exp_q.push_back(8'hCD);
    cyc();
    tag = 8'd0; master_valid = 4'b0001;
    @(negedge clk);
    chk("prereset_grant", master_ready, 4'b0001);
    chk("prereset_valid", slave_valid, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_slave_valid", slave_valid, 0);
    chk("midreset_slave_data", slave_data, 0);
    chk("midreset_master_ready", master_ready, 0);
    master_valid = '0;
    cyc();
    rst = 1'b0;

    // All IDs 5, masters 0,1,3 streaming -> round-robin 0,1,3,0,1,3
    set_id = 1'b1; ID_scan_in = 8'd5;
    repeat (4) cyc();
    set_id = 1'b0;
    tag = 8'd5; set_data(0, 8'h10); set_data(1, 8'h11); set_data(3, 8'h13);
    master_valid = 4'b1011; slave_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp_q.push_back(exp_dat[g]);
      @(negedge clk);
      chk("rr_grant", master_ready, exp_gnt[g]);
      cyc();
    end
    master_valid = '0;
    cyc(); cyc();

    // Backpressure: master 0 streams 1,2,3 with slave stalled
    slave_ready = 1'b0; master_valid = 4'b0001; set_data(0, 8'd1);
    exp_q.push_back(8'd1);
    @(negedge clk);
    chk("bp_grant_1", master_ready, 4'b0001);
    cyc();
    set_data(0, 8'd2);
    exp_q.push_back(8'd2);
    @(negedge clk);
    chk("bp_grant_2", master_ready, 4'b0001);
    cyc();
    set_data(0, 8'd3);
    exp_q.push_back(8'd3);
    @(negedge clk);
    chk("bp_full_ready", master_ready, 0);
    cyc();
    @(negedge clk);
    chk("bp_full_ready_hold", master_ready, 0);
    chk("bp_head_held", slave_data, 1);
    cyc();
    slave_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_full_ready", master_ready, 0);
    cyc();
    @(negedge clk);
    chk("bp_grant_3", master_ready, 4'b0001);
    cyc();
    master_valid = '0;
    cyc(); cyc();

    // Master 1 with non-matching tag is ignored until tag matches
    tag = 8'd7; set_data(1, 8'h77); master_valid = 4'b0010; slave_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nomatch_ready", master_ready, 0);
      chk("nomatch_slave_valid", slave_valid, 0);
      cyc();
    end
    tag = 8'd5;
    exp_q.push_back(8'h77);
    #1;
    chk("tag_match_grant", master_ready, 4'b0010);
    cyc();
    master_valid = '0;
    cyc(); cyc();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
